// File: rtl/mat_pkg.sv
// Shared types and index helpers for the matrix streaming blocks.
package mat_pkg;

    // Phase of the single-buffer transposer: fill the buffer, then empty it.
    typedef enum logic {
        LOAD  = 1'b0,
        DRAIN = 1'b1
    } state_e;

    // Width of a row or column index for an n x n matrix (n >= 2).
    function automatic int idx_w(input int n);
        return $clog2(n);
    endfunction

    // Row-major element index of (r, c) in an n x n matrix.
    function automatic int unsigned idx(input int unsigned r, input int unsigned c,
                                        input int unsigned n);
        return r * n + c;
    endfunction

endpackage

// File: rtl/mat_rc_counter.sv
// Row/column counter walking an N x N matrix in row-major order.
// Wraps back to (0,0) after the last element; clear forces (0,0).
module mat_rc_counter
    import mat_pkg::*;
#(
    parameter  int N  = 3,
    localparam int IW = idx_w(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          inc,
    output logic [IW-1:0] r,
    output logic [IW-1:0] c,
    output logic          at_end
);

    localparam logic [IW-1:0] LAST = IW'(N - 1);

    logic [IW-1:0] r_q, r_d;
    logic [IW-1:0] c_q, c_d;

    // Next position: column advances, carrying into the row, both wrapping.
    always_comb begin
        r_d = r_q;
        c_d = c_q;
        if (clear) begin
            r_d = '0;
            c_d = '0;
        end else if (inc) begin
            if (c_q == LAST) begin
                c_d = '0;
                r_d = (r_q == LAST) ? '0 : r_q + 1'b1;
            end else begin
                c_d = c_q + 1'b1;
            end
        end
    end

    // Position registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
            c_q <= '0;
        end else begin
            r_q <= r_d;
            c_q <= c_d;
        end
    end

    assign r      = r_q;
    assign c      = c_q;
    assign at_end = (r_q == LAST) && (c_q == LAST);

endmodule

// File: rtl/mat_stream_transposer.sv
// Element-serial N x N matrix transposer. Buffers one whole matrix arriving
// row-major, then emits its transpose row-major. Single buffer: load and
// drain phases never overlap.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The block holds out_valid, out_data and out_last stable until
// out_ready is seen; in_ready and out_valid are registered and depend only
// on the phase, never combinationally on the partner's valid/ready.
module mat_stream_transposer
    import mat_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int BIN_POS     = 8,
    parameter int MATRIX_SIZE = 3
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [DATA_WIDTH-1:0]                       in_data,
    input  logic                                        in_valid,
    input  logic                                        in_last,
    output logic                                        in_ready,
    output logic [DATA_WIDTH-1:0]                       out_data,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic                                        out_last,
    output logic [MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH-1:0] trans_flat,
    output logic                                        err
);

    localparam int N  = MATRIX_SIZE;
    localparam int W  = DATA_WIDTH;
    localparam int IW = idx_w(N);

    // The binary point only matters to the producer and consumer; data moves
    // as raw bits. Reject nonsensical settings at elaboration.
    if (BIN_POS < 0 || BIN_POS > DATA_WIDTH) begin : g_bad_bin_pos
        $error("BIN_POS must lie within DATA_WIDTH");
    end

    state_e         state_q, state_d;
    logic           in_ready_q, in_ready_d;
    logic           out_valid_q, out_valid_d;
    logic           err_q, err_d;
    logic [W-1:0]   mem_q [N][N];
    logic [W-1:0]   mem_d [N][N];

    logic [IW-1:0]  in_r, in_c, out_i, out_j;
    logic           in_end, out_end;
    logic           in_fire, out_fire;

    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = out_valid_q & out_ready;

    mat_rc_counter #(.N(N)) u_in_cnt (
        .clk    (clk),
        .rst    (rst),
        .clear  (state_q == DRAIN),
        .inc    (in_fire),
        .r      (in_r),
        .c      (in_c),
        .at_end (in_end)
    );

    mat_rc_counter #(.N(N)) u_out_cnt (
        .clk    (clk),
        .rst    (rst),
        .clear  (state_q == LOAD),
        .inc    (out_fire),
        .r      (out_i),
        .c      (out_j),
        .at_end (out_end)
    );

    // Phase sequencing, buffer writes and framing check on in_last.
    always_comb begin
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        err_d       = err_q;
        mem_d       = mem_q;
        case (state_q)
            LOAD: begin
                if (in_fire) begin
                    mem_d[in_r][in_c] = in_data;
                    // in_last only flags a framing error; the count alone
                    // decides where the matrix ends.
                    if (in_last != in_end) begin
                        err_d = 1'b1;
                    end
                    if (in_end) begin
                        state_d     = DRAIN;
                        in_ready_d  = 1'b0;
                        out_valid_d = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (out_fire && out_end) begin
                    state_d     = LOAD;
                    in_ready_d  = 1'b1;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = LOAD;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // FSM state, registered handshake outputs, sticky error and buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= LOAD;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    mem_q[r][c] <= '0;
                end
            end
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
            mem_q       <= mem_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign err       = err_q;
    // Transpose by swapped read indices; held steady by the output counter.
    assign out_data  = mem_q[out_j][out_i];
    assign out_last  = out_valid_q & out_end;

    // Flattened transpose: element (i,j) of the output is mem[j][i].
    for (genvar gi = 0; gi < N; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_col
            localparam int unsigned OFS = idx(gi, gj, N) * W;
            assign trans_flat[OFS +: W] = mem_q[gj][gi];
        end
    end

endmodule
